rr_arbiter_16: RTL and testbench

- 16-requester round-robin arbiter with registered, exclusive, one-hot grants, for sharing a single downstream resource.
- Fairness comes from a thermometer mask over requesters at or below the last-granted index.
- Grants are held while the owner keeps its request up, or until a tenure limit expires and others are waiting.
- Sits between request sources and a shared port; the grant index drives the port's select mux.

---
 rtl/rr_arb_pkg.sv | 32 +++
 rtl/mask_16.sv | 27 ++
 rtl/rr_arbiter_16.sv | 108 ++++++++++
 tb/tb_rr_arbiter_16.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and priority helper for the 16-way round-robin arbiter.
package rr_arb_pkg;

   localparam int N_REQ = 16;
   localparam int IDX_W = 4;
   localparam int CNT_W = 8;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } lowest_t;

   // Lowest set bit of a request vector; found=0 means the vector was empty.
   function automatic lowest_t lowest_set(input logic [N_REQ-1:0] vec);
      lowest_t r;
      r.found = 1'b0;
      r.idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (vec[i]) begin
            r.found = 1'b1;
            r.idx   = IDX_W'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mask_16.sv
// Thermometer mask generator: marks every position on one side of the input index.
// FROM_MSB=0 sets bits at or below the index, FROM_MSB=1 sets bits at or above it;
// DIAG_ONES chooses whether the index position itself is included.
module mask_16 #(
   parameter bit FROM_MSB  = 1'b0,
   parameter bit DIAG_ONES = 1'b1
) (
   input  logic [3:0]  in,
   output logic [15:0] out
);

   int sel;

   // Compare each bit position against the index to build the thermometer.
   always_comb begin
      out = '0;
      sel = int'(in);
      for (int i = 0; i < 16; i++) begin
         if (FROM_MSB) begin
            out[i] = DIAG_ONES ? (i >= sel) : (i > sel);
         end else begin
            out[i] = DIAG_ONES ? (i <= sel) : (i < sel);
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_16.sv
// 16-requester round-robin arbiter with registered one-hot grants and an optional
// tenure limit that only forces a handover when someone else is waiting.
import rr_arb_pkg::*;

module rr_arbiter_16 #(
   parameter int HOLD_MAX = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   output logic [N_REQ-1:0]     grant,
   output logic [IDX_W-1:0]     grant_idx,
   output logic                 grant_valid
);

   localparam bit              HOLD_EN   = (HOLD_MAX != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(HOLD_MAX - 1) : '0;

   state_t             state;
   state_t             state_next;
   logic [N_REQ-1:0]   grant_next;
   logic [IDX_W-1:0]   idx_next;
   logic [IDX_W-1:0]   last_ptr;
   logic [IDX_W-1:0]   last_next;
   logic [CNT_W-1:0]   tenure;
   logic [CNT_W-1:0]   tenure_next;
   logic [N_REQ-1:0]   mask;
   logic [N_REQ-1:0]   hi;
   lowest_t            pick_hi;
   lowest_t            pick_all;
   logic [IDX_W-1:0]   winner;
   logic               tenure_up;
   logic               others_waiting;
   logic               release_now;

   // Everything at or below the previous owner loses priority this round.
   mask_16 #(
      .FROM_MSB  (1'b0),
      .DIAG_ONES (1'b1)
   ) u_mask (
      .in  (last_ptr),
      .out (mask)
   );

   assign grant_valid = |grant;

   // Winner selection, release decision and next-state for the IDLE/GRANT machine.
   always_comb begin
      state_next     = state;
      grant_next     = grant;
      idx_next       = grant_idx;
      last_next      = last_ptr;
      tenure_next    = tenure;

      hi             = req & ~mask;
      pick_hi        = lowest_set(hi);
      pick_all       = lowest_set(req);
      winner         = pick_hi.found ? pick_hi.idx : pick_all.idx;

      tenure_up      = HOLD_EN && (tenure == HOLD_LAST);
      others_waiting = |(req & ~grant);
      release_now    = !req[grant_idx] || (tenure_up && others_waiting);

      case (state)
         IDLE: begin
            if (pick_all.found) begin
               state_next         = GRANT;
               grant_next         = '0;
               grant_next[winner] = 1'b1;
               idx_next           = winner;
               tenure_next        = '0;
            end
         end
         GRANT: begin
            if (release_now) begin
               state_next  = IDLE;
               grant_next  = '0;
               last_next   = grant_idx;
               tenure_next = '0;
            end else if (!tenure_up) begin
               tenure_next = tenure + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   // State, grant and round-robin pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         grant_idx <= '0;
         last_ptr  <= IDX_W'(N_REQ - 1);
         tenure    <= '0;
      end else begin
         state     <= state_next;
         grant     <= grant_next;
         grant_idx <= idx_next;
         last_ptr  <= last_next;
         tenure    <= tenure_next;
      end
   end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: directed vector table, hand-written corner
// sequences, and randomized traffic against a rotating-scan reference model.
module tb_rr_arbiter_16;

   logic        clk;
   logic        rst;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [15:0] grant_a;
   logic [3:0]  idx_a;
   logic        valid_a;
   logic [15:0] grant_b;
   logic [3:0]  idx_b;
   logic        valid_b;

   int checks;
   int errors;

   // Reference model state, one slot per DUT (0: HOLD_MAX=4, 1: HOLD_MAX=0).
   int m_owner[2];
   int m_last[2];
   int m_ten[2];
   int m_idx[2];

   typedef struct {
      logic [15:0] req;
      logic [15:0] grant;
      logic [3:0]  idx;
      logic        valid;
   } vec_t;

   vec_t vecs[12];

   rr_arbiter_16 #(.HOLD_MAX(4)) dut_a (
      .clk         (clk),
      .rst         (rst),
      .req         (req_a),
      .grant       (grant_a),
      .grant_idx   (idx_a),
      .grant_valid (valid_a)
   );

   rr_arbiter_16 #(.HOLD_MAX(0)) dut_b (
      .clk         (clk),
      .rst         (rst),
      .req         (req_b),
      .grant       (grant_b),
      .grant_idx   (idx_b),
      .grant_valid (valid_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs, let one rising edge happen, then settle for sampling.
   task automatic applyStimulus(input logic [15:0] ra, input logic [15:0] rb, input logic r);
      req_a = ra;
      req_b = rb;
      rst   = r;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name,
                              input logic [15:0] ag, input logic [3:0] ai, input logic av,
                              input logic [15:0] eg, input logic [3:0] ei, input logic ev);
      checks++;
      if (ag !== eg || ai !== ei || av !== ev) begin
         errors++;
         $display("[TB] FAIL %s: got grant=%h idx=%0d valid=%b, expected grant=%h idx=%0d valid=%b",
                  name, ag, ai, av, eg, ei, ev);
      end
   endtask

   task automatic checkInvariants(input string name,
                                  input logic [15:0] g, input logic [3:0] i, input logic v);
      checks++;
      if (!($countones(g) <= 1 && v === (|g) && g[i] === v)) begin
         errors++;
         $display("[TB] FAIL %s invariant: grant=%h idx=%0d valid=%b", name, g, i, v);
      end
   endtask

   // Spec-level model: owner scans cyclically from last+1; tenure limit only
   // forces a handover when another requester is waiting.
   task automatic modelStep(input int d, input logic [15:0] r, input logic rv, input int hold);
      logic [15:0] others;
      bit          expired;
      int          cand;
      if (rv) begin
         m_owner[d] = -1;
         m_last[d]  = 15;
         m_ten[d]   = 0;
         m_idx[d]   = 0;
      end else if (m_owner[d] < 0) begin
         for (int k = 1; k <= 16; k++) begin
            cand = (m_last[d] + k) % 16;
            if (r[cand] && m_owner[d] < 0) begin
               m_owner[d] = cand;
               m_idx[d]   = cand;
               m_ten[d]   = 0;
            end
         end
      end else begin
         others = r;
         others[m_owner[d]] = 1'b0;
         expired = (hold != 0) && (m_ten[d] >= hold - 1);
         if (!r[m_owner[d]] || (expired && others != 0)) begin
            m_last[d]  = m_owner[d];
            m_owner[d] = -1;
         end else if (!expired) begin
            m_ten[d] = m_ten[d] + 1;
         end
      end
   endtask

   function automatic logic [15:0] modelGrant(input int d);
      logic [15:0] g;
      g = '0;
      if (m_owner[d] >= 0) g[m_owner[d]] = 1'b1;
      return g;
   endfunction

   initial begin
      logic [15:0] eg;
      logic [3:0]  ei;
      logic        ev;
      logic [15:0] rnd_a;
      logic [15:0] rnd_b;
      logic        rnd_rst;
      int          k;

      checks = 0;
      errors = 0;
      req_a  = '0;
      req_b  = '0;
      rst    = 1'b1;

      vecs[0]  = '{16'h0001, 16'h0001, 4'd0,  1'b1};
      vecs[1]  = '{16'h0001, 16'h0001, 4'd0,  1'b1};
      vecs[2]  = '{16'h0000, 16'h0000, 4'd0,  1'b0};
      vecs[3]  = '{16'h8006, 16'h0002, 4'd1,  1'b1};
      vecs[4]  = '{16'h8004, 16'h0000, 4'd1,  1'b0};
      vecs[5]  = '{16'h8004, 16'h0004, 4'd2,  1'b1};
      vecs[6]  = '{16'h8000, 16'h0000, 4'd2,  1'b0};
      vecs[7]  = '{16'h8000, 16'h8000, 4'd15, 1'b1};
      vecs[8]  = '{16'h0002, 16'h0000, 4'd15, 1'b0};
      vecs[9]  = '{16'h0002, 16'h0002, 4'd1,  1'b1};
      vecs[10] = '{16'h0000, 16'h0000, 4'd1,  1'b0};
      vecs[11] = '{16'h0000, 16'h0000, 4'd1,  1'b0};

      // Reset state of both instances.
      applyStimulus(16'h0000, 16'h0000, 1'b1);
      applyStimulus(16'h0000, 16'h0000, 1'b1);
      checkOutput("reset_a", grant_a, idx_a, valid_a, 16'h0000, 4'd0, 1'b0);
      checkOutput("reset_b", grant_b, idx_b, valid_b, 16'h0000, 4'd0, 1'b0);

      // Directed table: single owner, rotation past last owner, wrap to low index.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].req, 16'h0000, 1'b0);
         checkOutput($sformatf("table_%0d", i), grant_a, idx_a, valid_a,
                     vecs[i].grant, vecs[i].idx, vecs[i].valid);
      end

      // HOLD_MAX=4 with two steady requesters: 4 cycles each, one dead cycle between.
      applyStimulus(16'h0000, 16'h0000, 1'b1);
      for (int c = 0; c < 20; c++) begin
         applyStimulus(16'h0003, 16'h0000, 1'b0);
         k  = c % 10;
         eg = (k < 4) ? 16'h0001 : (k == 4) ? 16'h0000 : (k < 9) ? 16'h0002 : 16'h0000;
         ei = (k < 5) ? 4'd0 : 4'd1;
         ev = (k != 4) && (k != 9);
         checkOutput($sformatf("tenure_pair_%0d", c), grant_a, idx_a, valid_a, eg, ei, ev);
      end

      // Lone owner past its tenure keeps the grant until a competitor shows up.
      applyStimulus(16'h0000, 16'h0000, 1'b0);
      applyStimulus(16'h0000, 16'h0000, 1'b0);
      for (int c = 0; c < 12; c++) begin
         applyStimulus(16'h0020, 16'h0000, 1'b0);
         checkOutput($sformatf("lone_owner_%0d", c), grant_a, idx_a, valid_a,
                     16'h0020, 4'd5, 1'b1);
      end
      applyStimulus(16'h0024, 16'h0000, 1'b0);
      checkOutput("competitor_release", grant_a, idx_a, valid_a, 16'h0000, 4'd5, 1'b0);
      applyStimulus(16'h0024, 16'h0000, 1'b0);
      checkOutput("competitor_grant", grant_a, idx_a, valid_a, 16'h0004, 4'd2, 1'b1);
      applyStimulus(16'h0000, 16'h0000, 1'b0);
      checkOutput("competitor_drop", grant_a, idx_a, valid_a, 16'h0000, 4'd2, 1'b0);

      // Unlimited tenure: owner 3 holds against full contention until it drops.
      applyStimulus(16'h0000, 16'h0008, 1'b0);
      checkOutput("unlimited_first", grant_b, idx_b, valid_b, 16'h0008, 4'd3, 1'b1);
      for (int c = 0; c < 300; c++) begin
         applyStimulus(16'h0000, 16'hFFFF, 1'b0);
         checkOutput($sformatf("unlimited_hold_%0d", c), grant_b, idx_b, valid_b,
                     16'h0008, 4'd3, 1'b1);
      end
      applyStimulus(16'h0000, 16'hFFF7, 1'b0);
      checkOutput("unlimited_release", grant_b, idx_b, valid_b, 16'h0000, 4'd3, 1'b0);
      applyStimulus(16'h0000, 16'hFFF7, 1'b0);
      checkOutput("unlimited_next", grant_b, idx_b, valid_b, 16'h0010, 4'd4, 1'b1);
      applyStimulus(16'h0000, 16'h0000, 1'b0);

      // Reset in the middle of a grant, then first arbitration favours requester 0.
      applyStimulus(16'h0200, 16'h0000, 1'b0);
      checkOutput("owner9_grant", grant_a, idx_a, valid_a, 16'h0200, 4'd9, 1'b1);
      applyStimulus(16'h0200, 16'h0000, 1'b0);
      applyStimulus(16'h0200, 16'h0000, 1'b1);
      checkOutput("midgrant_reset", grant_a, idx_a, valid_a, 16'h0000, 4'd0, 1'b0);
      applyStimulus(16'h0201, 16'h0000, 1'b0);
      checkOutput("post_reset_arb", grant_a, idx_a, valid_a, 16'h0001, 4'd0, 1'b1);

      // Randomized traffic on both instances against the reference model.
      applyStimulus(16'h0000, 16'h0000, 1'b1);
      modelStep(0, 16'h0000, 1'b1, 4);
      modelStep(1, 16'h0000, 1'b1, 0);
      rnd_a = '0;
      rnd_b = '0;
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < 16; b++) begin
            if ($urandom_range(0, 7) == 0) rnd_a[b] = ~rnd_a[b];
            if ($urandom_range(0, 7) == 0) rnd_b[b] = ~rnd_b[b];
         end
         rnd_rst = ($urandom_range(0, 149) == 0);
         applyStimulus(rnd_a, rnd_b, rnd_rst);
         modelStep(0, rnd_a, rnd_rst, 4);
         modelStep(1, rnd_b, rnd_rst, 0);
         checkOutput($sformatf("rand_a_%0d", c), grant_a, idx_a, valid_a,
                     modelGrant(0), 4'(m_idx[0]), m_owner[0] >= 0);
         checkOutput($sformatf("rand_b_%0d", c), grant_b, idx_b, valid_b,
                     modelGrant(1), 4'(m_idx[1]), m_owner[1] >= 0);
         checkInvariants("inv_a", grant_a, idx_a, valid_a);
         checkInvariants("inv_b", grant_b, idx_b, valid_b);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
